// File: rtl/sysmm_pkg.sv
// sysmm_pkg: shared FSM states, index-width helper and the clamping adder for systolic_mm_nxn.
package sysmm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  localparam int SW = 128;
  function automatic int iw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Operands arrive sign-extended to SW bits; the result is clamped to an aw-bit signed range.
  function automatic logic signed [SW-1:0] sat_add(input logic signed [SW-1:0] acc, prod, input int aw);
    logic signed [SW-1:0] s, hi, lo;
    s = acc + prod;
    hi = (SW'(1) << (aw - 1)) - 1;
    lo = -hi - 1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/sysmm_if.sv
// sysmm_if: load-beat and result-row handshakes of systolic_mm_nxn.
interface sysmm_if import sysmm_pkg::*; #(parameter int N = 3, parameter int DW = 32, parameter int AW = 2*DW+$clog2(N));
  logic in_valid, in_ready;
  logic [N*DW-1:0] in_a_col, in_b_row;
  logic out_valid, out_ready, out_last, out_sat, busy;
  logic [N*AW-1:0] out_row;
  logic [iw(N)-1:0] out_row_idx;
  modport master(output in_valid, in_a_col, in_b_row, out_ready,
                 input in_ready, out_valid, out_row, out_row_idx, out_last, out_sat, busy);
  modport slave(input in_valid, in_a_col, in_b_row, out_ready,
                output in_ready, out_valid, out_row, out_row_idx, out_last, out_sat, busy);
endinterface

// File: rtl/sysmm_pe.sv
// sysmm_pe: output-stationary MAC cell with a/b forwarding.
// SYSMM_ACC_SAT_EN selects clamping accumulation with a sticky saturation flag.
module sysmm_pe import sysmm_pkg::*; #(parameter int DW = 32, parameter int AW = 66) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic signed [AW-1:0] acc,
  output logic sat
);
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0] nxt;
  assign prod = a_in * b_in;
`ifdef SYSMM_ACC_SAT_EN
  logic signed [SW-1:0] acc_w, prod_w, sum_w;
  assign acc_w = acc;
  assign prod_w = prod;
  assign sum_w = sat_add(acc_w, prod_w, AW);
  assign nxt = sum_w[AW-1:0];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sat <= 1'b0;
    else if (clr) sat <= 1'b0;
    else if (en && sum_w != acc_w + prod_w) sat <= 1'b1;
`else
  assign nxt = acc + AW'(prod);
  assign sat = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      a_out <= '0;
      b_out <= '0;
      acc <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc <= nxt;
    end
endmodule

// File: rtl/systolic_mm_nxn.sv
// systolic_mm_nxn: N x N output-stationary systolic multiplier C = A*B with internal skew and row drain.
// Optional clamping accumulation under SYSMM_ACC_SAT_EN.
module systolic_mm_nxn import sysmm_pkg::*; #(
  parameter int N = 3,
  parameter int DW = 32,
  parameter int AW = 2*DW+$clog2(N)
) (
  input logic clock,
  input logic reset_n,
  sysmm_if.slave bus
);
  localparam int IW = iw(N);
  localparam int TW = iw(3*N-2);
  state_t state, nxt;
  logic [IW-1:0] cnt, row, idx;
  logic [TW-1:0] t;
  logic signed [DW-1:0] a_buf [N][N];
  logic signed [DW-1:0] b_buf [N][N];
  logic signed [DW-1:0] a_inj [N];
  logic signed [DW-1:0] b_inj [N];
  logic signed [DW-1:0] a_w [N][N];
  logic signed [DW-1:0] b_w [N][N];
  logic signed [AW-1:0] c [N][N];
  logic [N*N-1:0] sat;
  logic take, fire, clr, en, unused_fwd;
  assign take = bus.in_valid & bus.in_ready;
  assign fire = bus.out_valid & bus.out_ready;
  assign clr = take && state == IDLE;
  assign en = state == COMPUTE;
  assign idx = state == IDLE ? '0 : cnt;
  assign bus.in_ready = state == IDLE || state == LOAD;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = state == DRAIN;
  assign bus.out_last = bus.out_valid && row == IW'(N-1);
  assign bus.out_row_idx = row;
  assign bus.out_sat = |sat;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = take ? (N == 1 ? COMPUTE : LOAD) : IDLE;
      LOAD:    nxt = take && cnt == IW'(N-1) ? COMPUTE : LOAD;
      COMPUTE: nxt = t == TW'(3*N-3) ? DRAIN : COMPUTE;
      DRAIN:   nxt = fire && bus.out_last ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      row <= '0;
      t <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
        end
    end else begin
      if (take) begin
        for (int i = 0; i < N; i++) begin
          a_buf[i][idx] <= bus.in_a_col[i*DW +: DW];
          b_buf[idx][i] <= bus.in_b_row[i*DW +: DW];
        end
        cnt <= idx + 1'b1;
      end
      t <= en ? t + 1'b1 : '0;
      if (fire) row <= bus.out_last ? '0 : row + 1'b1;
    end
  // Row i and column i both inject operand index k = t - i while it lies inside the matrix.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = '0;
      b_inj[i] = '0;
      if (en && int'(t) >= i && int'(t) - i < N) begin
        a_inj[i] = a_buf[i][IW'(int'(t) - i)];
        b_inj[i] = b_buf[IW'(int'(t) - i)][i];
      end
    end
  end
  always_comb begin
    bus.out_row = '0;
    for (int j = 0; j < N; j++) bus.out_row[j*AW +: AW] = bus.out_valid ? c[row][j] : '0;
  end
  always_comb begin
    unused_fwd = 1'b0;
    for (int i = 0; i < N; i++) unused_fwd = unused_fwd ^ (^a_w[i][N-1]) ^ (^b_w[N-1][i]);
  end
  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      logic signed [DW-1:0] a_i, b_i;
      if (j == 0) begin : g_a0
        assign a_i = a_inj[i];
      end else begin : g_an
        assign a_i = a_w[i][j-1];
      end
      if (i == 0) begin : g_b0
        assign b_i = b_inj[j];
      end else begin : g_bn
        assign b_i = b_w[i-1][j];
      end
      sysmm_pe #(.DW(DW), .AW(AW)) u_pe (
        .clock(clock), .reset_n(reset_n), .clr(clr), .en(en),
        .a_in(a_i), .b_in(b_i), .a_out(a_w[i][j]), .b_out(b_w[i][j]),
        .acc(c[i][j]), .sat(sat[i*N+j])
      );
    end
  end
endmodule

// File: tb/tb_systolic_mm_nxn.sv
// tb_systolic_mm_nxn: directed scoreboard bench for the 3x3 default build plus a 4x4/DW=8/AW=12 overflow job.
module tb_systolic_mm_nxn;
  localparam int N = 3, DW = 32, AW = 2*DW+$clog2(N);
  localparam int N4 = 4, DW4 = 8, AW4 = 12;
  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;
  sysmm_if #(.N(N), .DW(DW), .AW(AW)) bus();
  sysmm_if #(.N(N4), .DW(DW4), .AW(AW4)) bus4();
  systolic_mm_nxn #(.N(N), .DW(DW), .AW(AW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  systolic_mm_nxn #(.N(N4), .DW(DW4), .AW(AW4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4.slave));
  typedef struct { logic [N*AW-1:0] row; int idx; logic last; } exp_t;
  exp_t sb[$];
  int errs = 0, checks = 0;
  int A[N][N], B[N][N];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_model();
    exp_t e;
    for (int r = 0; r < N; r++) begin
      e.row = '0;
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(A[r][k]) * longint'(B[k][j]);
        e.row[j*AW +: AW] = AW'(s);
      end
      e.idx = r;
      e.last = (r == N-1);
      sb.push_back(e);
    end
  endtask

  task automatic load_job(input bit gap, input bit measure);
    int n;
    for (int k = 0; k < N; k++) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.in_a_col[i*DW +: DW] = A[i][k];
        bus.in_b_row[i*DW +: DW] = B[k][i];
      end
      chk("load_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      if (gap && k < N-1) begin
        bus.in_a_col = {N{$urandom}};
        bus.in_b_row = {N{$urandom}};
        tick();
      end
    end
    push_model();
    if (measure) begin
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_a_col = {N{$urandom}};
      while (!bus.out_valid && n < 50) begin
        tick();
        n++;
      end
      bus.in_valid = 1'b0;
      chk("latency", n, 3*N-2);
    end
  endtask

  task automatic drain(input int stall_row);
    exp_t e;
    int w;
    while (sb.size() > 0) begin
      w = 0;
      while (!bus.out_valid && w < 50) begin
        tick();
        w++;
      end
      chk("out_valid", bus.out_valid, 1);
      if (!bus.out_valid) begin
        sb.delete();
        return;
      end
      e = sb.pop_front();
      if (e.idx == stall_row) begin
        bus.out_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("hold_row", bus.out_row, e.row);
          chk("hold_idx", bus.out_row_idx, e.idx);
          chk("hold_in_ready", bus.in_ready, 0);
        end
      end
      bus.out_ready = 1'b1;
      chk("row", bus.out_row, e.row);
      chk("row_idx", bus.out_row_idx, e.idx);
      chk("last", bus.out_last, e.last);
      chk("drain_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_out_sat"}, bus.out_sat, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_out_row"}, bus.out_row, 0);
    chk({tag, "_out_row_idx"}, bus.out_row_idx, 0);
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = (i == j) ? 1 : 0;
      end
  endtask

  initial begin
    logic signed [AW4-1:0] lane4;
    logic sat4;
    int w;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a_col = '0;
    bus.in_b_row = '0;
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.in_a_col = '0;
    bus4.in_b_row = '0;
    repeat (3) tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();
    // A = 1..9, B = identity
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = i*N + j + 1;
        B[i][j] = (i == j) ? 1 : 0;
      end
    load_job(1'b0, 1'b1);
    drain(-1);
    // A all -2, B all 3: every entry -18
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = -2;
        B[i][j] = 3;
      end
    load_job(1'b0, 1'b1);
    drain(-1);
    // Back-pressure on row 1 with a dense signed B
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = i*N + j + 1;
        B[i][j] = (i + 2*j) - 3;
      end
    load_job(1'b0, 1'b1);
    drain(1);
    // Gapped load with random signed operands
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = int'($urandom_range(0, 2000)) - 1000;
        B[i][j] = int'($urandom_range(0, 2000)) - 1000;
      end
    load_job(1'b1, 1'b1);
    drain(-1);
    // Abort mid-compute with an asynchronous reset, then a clean identity job
    set_identity();
    for (int i = 0; i < N; i++) A[i][i] = 5;
    load_job(1'b0, 1'b0);
    repeat (3) tick();
    chk("abort_busy", bus.busy, 1);
    reset_n = 1'b0;
    #2;
    sb.delete();
    check_reset_values("abort");
    tick();
    reset_n = 1'b1;
    tick();
    set_identity();
    load_job(1'b0, 1'b1);
    drain(-1);
    // 4x4, DW=8, AW=12, all operands 127: saturates or wraps depending on the build
`ifdef SYSMM_ACC_SAT_EN
    lane4 = 12'sd2047;
    sat4 = 1'b1;
`else
    lane4 = -12'sd1020;
    sat4 = 1'b0;
`endif
    bus4.in_a_col = {N4{8'sd127}};
    bus4.in_b_row = {N4{8'sd127}};
    bus4.in_valid = 1'b1;
    repeat (N4) tick();
    bus4.in_valid = 1'b0;
    w = 0;
    while (!bus4.out_valid && w < 50) begin
      tick();
      w++;
    end
    chk("n4_latency", w, 3*N4-2);
    for (int r = 0; r < N4; r++) begin
      chk("n4_row", bus4.out_row, {N4{lane4}});
      chk("n4_idx", bus4.out_row_idx, r);
      chk("n4_sat", bus4.out_sat, sat4);
      bus4.out_ready = 1'b1;
      tick();
    end
    bus4.out_ready = 1'b0;
    chk("n4_idle", bus4.busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
